flag_register: RTL and testbench
================================

Name: flag_register

Overview:
- Architectural N/Z/V flag state for the 16-bit processor.
- Sits directly upstream of pc_register and drives its `flags[2:0]` input as {N, Z, V}.
- Samples ALU operands, ALU result and the executing opcode, then updates the selected flags on the clock edge that retires the instruction.
- Freezes after HLT so branch evaluation stays stable while the core is halted.

Parameters:
- WIDTH, 16, datapath width of ALU operands and result.
- OPCODE_W, 4, width of the opcode field.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  current opcode/operands belong to a real instruction; 0 = bubble.
- stall  input  1  hold all state this cycle.
- opcode  input  OPCODE_W  instruction[15:12] of the executing instruction.
- alu_a  input  WIDTH  first ALU operand (rs).
- alu_b  input  WIDTH  second ALU operand (rt).
- alu_result  input  WIDTH  final ALU result; ADD/SUB already saturated.
- flags  output  3  registered {N, Z, V}, consumed by pc_register.
- halted  output  1  set once HLT retires; sticky until reset.

Behaviour:
- Reset (async, rst_n low): flags = 3'b000, halted = 0 immediately, independent of clk. Both hold while rst_n is low.
- Update enable: `upd = instr_valid & ~stall & ~halted`. When upd = 0, flags and halted hold.
- Per-opcode update masks (only when upd = 1):
  - ADD (0x0), SUB (0x1): N, Z and V all written.
  - XOR (0x2), SLL (0x4), SRA (0x5), ROR (0x6): only Z written; N and V hold.
  - All other opcodes, including RED, PADDSB, LW, SW, LLB, LHB, B, BR, PCS: no flag change.
  - HLT (0xF): no flag change; halted set to 1 on the same edge.
- Flag arithmetic:
  - Z = (alu_result == 0).
  - N = alu_result[WIDTH-1].
  - V for ADD: raw = alu_a + alu_b, truncated to WIDTH; V = (a_msb == b_msb) & (raw_msb != a_msb).
  - V for SUB: raw = alu_a - alu_b; V = (a_msb != b_msb) & (raw_msb != a_msb).
  - V is computed from raw operands, never from the saturated result.
- Latency: flags reflect an instruction one clock after the edge on which it is sampled. A branch in the next cycle therefore sees the updated flags.
- Simultaneous events:
  - stall = 1 with HLT: halted is not set; HLT is re-presented later.
  - instr_valid = 0 with any opcode: ignored.
- halted = 1 blocks all updates, including a further HLT (no effect). Only rst_n clears it.
- Reset asserted mid-stall or while halted: full clear; normal operation resumes on the first edge after rst_n rises.
- Must not modify flags on a cycle where pc_register's branch consumes them, except through the registered path.

Optional Feature:
- Macro: FLAG_BYPASS_EN.
- Defined:
  - Extra output port `flags_next[2:0]`, combinational value that flags will take at the next posedge. Equals flags when upd = 0.
  - Used by a later pipelined branch unit to resolve a branch in the same cycle as the flag-setting instruction.
- Undefined: the port is absent. flags is the only flag output, and behaviour is otherwise identical.

Test Plan:
- ADD, alu_a=0x7FFF, alu_b=0x0001, alu_result=0x7FFF (saturated) -> next cycle flags=3'b001 (N=0, Z=0, V=1).
- SUB, alu_a=0x0005, alu_b=0x0005, alu_result=0x0000 -> flags=3'b010. Then ADD, 0x8000+0xFFFF with result 0x8000 -> flags=3'b101.
- From flags=3'b101, XOR with alu_result=0x0000 -> flags=3'b111 (Z set, N/V retained). Then SLL with result 0x0010 -> flags=3'b101.
- ADD 0x0000+0x0000 with stall=1 for 3 cycles, or with instr_valid=0 -> flags unchanged throughout. Releasing stall -> flags=3'b010 one cycle later.
- HLT retires -> halted=1. Following SUB giving 0 over 50 cycles -> flags and halted unchanged. Pulse rst_n low for 1 ns between edges -> flags=3'b000 and halted=0 immediately (async).
- With FLAG_BYPASS_EN: ADD giving V=1 -> flags_next=3'b001 in the same cycle, and flags=3'b001 after the edge. With stall=1, flags_next equals flags.

Source files
------------

// File: rtl/flag_register.sv
// Architectural N/Z/V flag state plus sticky halt for the 16-bit core.
// Define FLAG_BYPASS_EN to expose the combinational next-state flags as flags_next.
module flag_register #(
    parameter int WIDTH    = 16,
    parameter int OPCODE_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid,
    input  logic                stall,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [WIDTH-1:0]    alu_a,
    input  logic [WIDTH-1:0]    alu_b,
    input  logic [WIDTH-1:0]    alu_result,
    output logic [2:0]          flags,
    output logic                halted
`ifdef FLAG_BYPASS_EN
    ,
    output logic [2:0]          flags_next
`endif
);

    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'h0);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'h1);
    localparam logic [OPCODE_W-1:0] OP_XOR = OPCODE_W'(4'h2);
    localparam logic [OPCODE_W-1:0] OP_SLL = OPCODE_W'(4'h4);
    localparam logic [OPCODE_W-1:0] OP_SRA = OPCODE_W'(4'h5);
    localparam logic [OPCODE_W-1:0] OP_ROR = OPCODE_W'(4'h6);
    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'hF);

    // Bit positions inside the {N, Z, V} vector.
    localparam int N_BIT = 2;
    localparam int Z_BIT = 1;
    localparam int V_BIT = 0;

    logic [2:0]       flags_q, flags_d;
    logic             halted_q, halted_d;
    logic             upd;
    logic [WIDTH-1:0] raw_sum;
    logic [WIDTH-1:0] raw_diff;
    logic             a_msb, b_msb;
    logic             n_res, z_res;
    logic             v_add, v_sub;

    // Overflow comes from the unsaturated arithmetic, so recompute it here
    // rather than trusting alu_result, which has already been clamped.
    always_comb begin
        raw_sum  = alu_a + alu_b;
        raw_diff = alu_a - alu_b;
        a_msb    = alu_a[WIDTH-1];
        b_msb    = alu_b[WIDTH-1];
        v_add    = (a_msb == b_msb) & (raw_sum[WIDTH-1] != a_msb);
        v_sub    = (a_msb != b_msb) & (raw_diff[WIDTH-1] != a_msb);
        n_res    = alu_result[WIDTH-1];
        z_res    = (alu_result == '0);
    end

    // NOTE: every always_comb output is given a hold default before the case,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        upd      = instr_valid & ~stall & ~halted_q;
        flags_d  = flags_q;
        halted_d = halted_q;
        if (upd) begin
            case (opcode)
                OP_ADD: flags_d = {n_res, z_res, v_add};
                OP_SUB: flags_d = {n_res, z_res, v_sub};
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_d[Z_BIT] = z_res;
                OP_HLT: halted_d = 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so every register
    // samples its pre-edge value regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q  <= 3'b000;
            halted_q <= 1'b0;
        end else begin
            flags_q  <= flags_d;
            halted_q <= halted_d;
        end
    end

    assign flags  = flags_q;
    assign halted = halted_q;

`ifdef FLAG_BYPASS_EN
    assign flags_next = flags_d;
`endif

    // N_BIT and V_BIT document the layout; referenced here to keep them live.
    logic unused_layout;
    assign unused_layout = (N_BIT == 2) & (V_BIT == 0);

endmodule

// File: tb/tb_flag_register.sv
// Self-checking bench for flag_register: directed test-plan steps plus random
// traffic checked against a signed-arithmetic reference model.
module tb_flag_register;

    localparam int WIDTH    = 16;
    localparam int OPCODE_W = 4;

    logic                clk;
    logic                rst_n;
    logic                instr_valid;
    logic                stall;
    logic [OPCODE_W-1:0] opcode;
    logic [WIDTH-1:0]    alu_a;
    logic [WIDTH-1:0]    alu_b;
    logic [WIDTH-1:0]    alu_result;
    logic [2:0]          flags;
    logic                halted;
`ifdef FLAG_BYPASS_EN
    logic [2:0]          flags_next;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference state
    logic [2:0] m_flags;
    logic       m_halted;

    flag_register #(.WIDTH(WIDTH), .OPCODE_W(OPCODE_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_valid(instr_valid),
        .stall      (stall),
        .opcode     (opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .flags      (flags),
        .halted     (halted)
`ifdef FLAG_BYPASS_EN
        ,
        .flags_next (flags_next)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: flags from the signed meaning of the operands.
    function automatic logic [3:0] model_next(input logic v, input logic s,
                                              input logic [3:0] op,
                                              input logic [15:0] a,
                                              input logic [15:0] b,
                                              input logic [15:0] r);
        int sa, sb, t;
        logic [2:0] f;
        logic       h;
        f  = m_flags;
        h  = m_halted;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (v && !s && !m_halted) begin
            if (op == 4'h0 || op == 4'h1) begin
                t = (op == 4'h0) ? sa + sb : sa - sb;
                f = {($signed(r) < 0), (r == 16'd0), (t > 32767 || t < -32768)};
            end else if (op == 4'h2 || op == 4'h4 || op == 4'h5 || op == 4'h6) begin
                f[1] = (r == 16'd0);
            end else if (op == 4'hF) begin
                h = 1'b1;
            end
        end
        return {f, h};
    endfunction

    // One clock: drive inputs after the edge, check bypass mid-cycle, then
    // check the registered outputs 1 ns after the next edge.
    task automatic step(input string tag, input logic v, input logic s,
                        input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] r);
        logic [3:0] exp;
        instr_valid = v;
        stall       = s;
        opcode      = op;
        alu_a       = a;
        alu_b       = b;
        alu_result  = r;
        exp = model_next(v, s, op, a, b, r);
        #2;
`ifdef FLAG_BYPASS_EN
        check({tag, "_bypass"}, {1'b0, flags_next}, {1'b0, exp[3:1]});
`endif
        @(posedge clk);
        #1;
        m_flags  = exp[3:1];
        m_halted = exp[0];
        check({tag, "_flags"}, {1'b0, flags}, {1'b0, m_flags});
        check({tag, "_halted"}, {3'b000, halted}, {3'b000, m_halted});
    endtask

    task automatic reset_pulse(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        m_flags  = 3'b000;
        m_halted = 1'b0;
        check({tag, "_flags"}, {1'b0, flags}, 4'h0);
        check({tag, "_halted"}, {3'b000, halted}, 4'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0]  op;
        logic [15:0] a, b, r;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        stall       = 1'b0;
        opcode      = '0;
        alu_a       = '0;
        alu_b       = '0;
        alu_result  = '0;
        m_flags     = 3'b000;
        m_halted    = 1'b0;
        #3;
        check("reset_flags", {1'b0, flags}, 4'h0);
        check("reset_halted", {3'b000, halted}, 4'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        step("add_sat_ovf", 1, 0, 4'h0, 16'h7FFF, 16'h0001, 16'h7FFF);
        check("plan_add_ovf", {1'b0, flags}, 4'b0001);
        step("sub_zero", 1, 0, 4'h1, 16'h0005, 16'h0005, 16'h0000);
        check("plan_sub_zero", {1'b0, flags}, 4'b0010);
        step("add_neg_ovf", 1, 0, 4'h0, 16'h8000, 16'hFFFF, 16'h8000);
        check("plan_add_neg", {1'b0, flags}, 4'b0101);
        step("xor_zero", 1, 0, 4'h2, 16'h1234, 16'h1234, 16'h0000);
        check("plan_xor", {1'b0, flags}, 4'b0111);
        step("sll_nz", 1, 0, 4'h4, 16'h0001, 16'h0004, 16'h0010);
        check("plan_sll", {1'b0, flags}, 4'b0101);
        for (int i = 0; i < 3; i++)
            step("stall_add", 1, 1, 4'h0, 16'h0000, 16'h0000, 16'h0000);
        step("bubble_add", 0, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000);
        check("plan_hold", {1'b0, flags}, 4'b0101);
        step("release_add", 1, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000);
        check("plan_release", {1'b0, flags}, 4'b0010);
        step("sub_neg_ovf", 1, 0, 4'h1, 16'h8000, 16'h0001, 16'h8000);
        step("sra_other", 1, 0, 4'h5, 16'h8000, 16'h0001, 16'h0000);
        step("ror_other", 1, 0, 4'h6, 16'h8000, 16'h0001, 16'h0001);
        step("lw_noop", 1, 0, 4'h8, 16'h0000, 16'h0000, 16'h0000);

        // Random traffic, HLT excluded so the run keeps updating.
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 14));
            a  = 16'($urandom);
            b  = 16'($urandom);
            r  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            step("rand", ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0), op, a, b, r);
        end

        step("hlt_stalled", 1, 1, 4'hF, 16'h0000, 16'h0000, 16'h0000);
        check("hlt_stall_not_halted", {3'b000, halted}, 4'h0);
        step("hlt_bubble", 0, 0, 4'hF, 16'h0000, 16'h0000, 16'h0000);
        step("hlt", 1, 0, 4'hF, 16'h0000, 16'h0000, 16'h0000);
        check("plan_halted", {3'b000, halted}, 4'h1);
        for (int i = 0; i < 50; i++)
            step("halted_sub", 1, 0, 4'h1, 16'h0003, 16'h0003, 16'h0000);
        step("halted_hlt", 1, 0, 4'hF, 16'h0000, 16'h0000, 16'h0000);
        reset_pulse("async_rst_halted");

        step("post_rst_add", 1, 0, 4'h0, 16'h7FFF, 16'h0001, 16'h7FFF);
        check("post_rst_flags", {1'b0, flags}, 4'b0001);
        step("stall_pre_rst", 1, 1, 4'h1, 16'h0000, 16'h0000, 16'h0000);
        reset_pulse("async_rst_stall");
        step("post_rst_sub", 1, 0, 4'h1, 16'h0000, 16'h0001, 16'hFFFF);
        check("post_rst_sub_flags", {1'b0, flags}, 4'b0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
